modn_updn_counter: RTL and testbench

MODN_UPDN_COUNTER -- requirements
Module: modn_updn_counter

---
 rtl/modn_updn_counter.sv | 91 +++++++++
 tb/tb_modn_updn_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/modn_updn_counter.sv
// Modulo-MODULUS up/down counter with sync clear, optional parallel load, chainable CO and sticky OVF.
// Define MODN_CNT_LOAD_EN to enable LD/D; otherwise those ports are accepted but ignored.
module modn_updn_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             OVF
);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             load_act;
    logic [WIDTH-1:0] load_val;
    logic             in_range;
    logic             at_top;
    logic             at_zero;
    logic             wrap;

`ifdef MODN_CNT_LOAD_EN
    // Out-of-range load data saturates to the terminal count.
    assign load_act = LD;
    assign load_val = ({1'b0, D} >= MOD_X) ? TOP : D;
`else
    logic unused_load;
    assign unused_load = ^{LD, D};
    assign load_act    = 1'b0;
    assign load_val    = '0;
`endif

    assign in_range = ({1'b0, q_q} < MOD_X);
    assign at_top   = (q_q == TOP);
    assign at_zero  = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        wrap  = 1'b0;
        if (CLR) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load_act) begin
            q_d = load_val;
        end else if (EN) begin
            if (!in_range) begin
                q_d = '0;
            end else if (UP) begin
                if (at_top) begin
                    q_d  = '0;
                    wrap = 1'b1;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    q_d  = TOP;
                    wrap = 1'b1;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
            if (wrap) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // CO is suppressed while a clear or load overrides counting, so a chained stage never steps spuriously.
    assign CO  = EN & ~CLR & ~load_act & (UP ? at_top : at_zero);
    assign Q   = q_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_modn_updn_counter.sv
// Bench for modn_updn_counter (WIDTH=4, MODULUS=12): vector table, directed corner sequences, random vs model.
module tb_modn_updn_counter;
  localparam int M = 12;
`ifdef MODN_CNT_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       MR = 1'b0;
  logic       CLR = 1'b0;
  logic       LD = 1'b0;
  logic [3:0] D = '0;
  logic       EN = 1'b0;
  logic       UP = 1'b1;
  logic [3:0] Q;
  logic       CO;
  logic       OVF;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  int   m_q = 0;
  bit   m_ovf = 1'b0;
  bit   m_co = 1'b0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       clr;
    logic       en;
    logic       up;
    logic [3:0] exp_q;
    logic       exp_co;
    logic       exp_ovf;
  } vec_t;
  vec_t tbl[10];

  modn_updn_counter #(.WIDTH(4), .MODULUS(12)) dut (
    .CLK(CLK), .MR(MR), .CLR(CLR), .LD(LD), .D(D),
    .EN(EN), .UP(UP), .Q(Q), .CO(CO), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    MR = 1'b0;
    CLR = 1'b0; LD = 1'b0; EN = 1'b0;
    repeat (2) @(negedge CLK);
    MR = 1'b1;
    m_q = 0;
    m_ovf = 1'b0;
  endtask

  // One clock: drive at negedge, sample CO before the edge and Q/OVF just after it.
  task automatic drive_edge(input logic clr, input logic ld, input logic [3:0] d,
                            input logic en, input logic up,
                            output logic co_s, output logic [3:0] q_s, output logic ovf_s);
    int nq;
    bit w;
    @(negedge CLK);
    CLR = clr; LD = ld; D = d; EN = en; UP = up;
    #1;
    co_s = CO;
    w = 1'b0;
    m_co = en && !clr && !(LOAD_ON && ld) && ((up && m_q == M - 1) || (!up && m_q == 0));
    if (clr) nq = 0;
    else if (LOAD_ON && ld) nq = (int'(d) >= M) ? M - 1 : int'(d);
    else if (en && up) begin
      nq = (m_q + 1) % M;
      w = (m_q == M - 1);
    end else if (en) begin
      nq = (m_q + M - 1) % M;
      w = (m_q == 0);
    end else nq = m_q;
    exp_q.push_back(4'(nq));
    @(posedge CLK);
    #1;
    q_s = Q;
    ovf_s = OVF;
    m_q = nq;
    if (clr) m_ovf = 1'b0;
    else if (w) m_ovf = 1'b1;
  endtask

  task automatic model_step(input logic clr, input logic ld, input logic [3:0] d,
                            input logic en, input logic up);
    logic co_s, ovf_s;
    logic [3:0] q_s;
    drive_edge(clr, ld, d, en, up, co_s, q_s, ovf_s);
    check("co", int'(co_s), int'(m_co));
    check("q", int'(q_s), int'(exp_q.pop_front()));
    check("ovf", int'(ovf_s), int'(m_ovf));
  endtask

  initial begin
    logic co_s, ovf_s;
    logic [3:0] q_s;

    tbl[0] = '{clr: 0, en: 1, up: 0, exp_q: 11, exp_co: 1, exp_ovf: 1};
    tbl[1] = '{clr: 0, en: 1, up: 1, exp_q: 0,  exp_co: 1, exp_ovf: 1};
    tbl[2] = '{clr: 0, en: 0, up: 1, exp_q: 0,  exp_co: 0, exp_ovf: 1};
    tbl[3] = '{clr: 0, en: 1, up: 1, exp_q: 1,  exp_co: 0, exp_ovf: 1};
    tbl[4] = '{clr: 0, en: 1, up: 1, exp_q: 2,  exp_co: 0, exp_ovf: 1};
    tbl[5] = '{clr: 1, en: 1, up: 1, exp_q: 0,  exp_co: 0, exp_ovf: 0};
    tbl[6] = '{clr: 0, en: 1, up: 0, exp_q: 11, exp_co: 1, exp_ovf: 1};
    tbl[7] = '{clr: 0, en: 0, up: 1, exp_q: 11, exp_co: 0, exp_ovf: 1};
    tbl[8] = '{clr: 0, en: 1, up: 0, exp_q: 10, exp_co: 0, exp_ovf: 1};
    tbl[9] = '{clr: 1, en: 0, up: 0, exp_q: 0,  exp_co: 0, exp_ovf: 0};

    // reset state, and CO evaluated against Q=0 while reset is held
    #1;
    check("reset_q", int'(Q), 0);
    check("reset_ovf", int'(OVF), 0);
    check("reset_co_idle", int'(CO), 0);
    EN = 1'b1; UP = 1'b0;
    #1;
    check("reset_co_down", int'(CO), 1);
    @(posedge CLK);
    #1;
    check("reset_q_held", int'(Q), 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive_edge(tbl[i].clr, 1'b0, 4'd0, tbl[i].en, tbl[i].up, co_s, q_s, ovf_s);
      void'(exp_q.pop_front());
      check($sformatf("tbl%0d_co", i), int'(co_s), int'(tbl[i].exp_co));
      check($sformatf("tbl%0d_q", i), int'(q_s), int'(tbl[i].exp_q));
      check($sformatf("tbl%0d_ovf", i), int'(ovf_s), int'(tbl[i].exp_ovf));
    end

    // 13 up-steps from 0: 1..11, 0, 1
    do_reset();
    for (int i = 0; i < 13; i++) model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("up13_q", int'(Q), 1);
    check("up13_ovf", int'(OVF), 1);

    // down from 1: 0, 11, 10
    model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("down_q", int'(Q), 10);
    check("down_ovf", int'(OVF), 1);

    // enable toggling from 3: 4,4,5,6
    model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("entog_q", int'(Q), 6);

    // load behaviour at Q=2
    model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    model_step(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    check("ld9_q", int'(Q), LOAD_ON ? 9 : 3);
    model_step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    check("ld5_q", int'(Q), LOAD_ON ? 5 : 3);
    model_step(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    check("ld14_q", int'(Q), LOAD_ON ? 11 : 3);
    model_step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("hold_co_top", int'(CO), 0);
    model_step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    check("ldclr_q", int'(Q), 0);
    check("ldclr_ovf", int'(OVF), 0);

    // asynchronous reset mid-count at Q=7 with OVF set
    do_reset();
    for (int i = 0; i < 19; i++) model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("pre_mr_q", int'(Q), 7);
    #3;
    MR = 1'b0;
    #1;
    check("mr_async_q", int'(Q), 0);
    check("mr_async_ovf", int'(OVF), 0);
    #100;
    MR = 1'b1;
    m_q = 0;
    m_ovf = 1'b0;
    model_step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      model_step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
